instr_prefetch_ctrl: RTL

INSTR_PREFETCH_CTRL -- requirements
Module: instr_prefetch_ctrl

---
 rtl/instr_prefetch_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/instr_prefetch_ctrl.sv
// Instruction prefetch controller: streams instr_count words from base_addr into a downstream FIFO.
// Latency: read data arrives one cycle after i_instr_rd_en and is written that same cycle when the FIFO has room.
// Backpressure: fifo_full parks one word in a skid register and stalls reads; INSTR_PREFETCH_EOP_EN adds an end-of-program opcode.
module instr_prefetch_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [15:0]            instr_count,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  output logic [ADDR_WIDTH-1:0]  i_instr_addr,
  output logic                   i_instr_rd_en,
  input  logic                   fifo_full,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic                   o_instr_wr_en,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            fetched
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_t                 state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [15:0]            remain_q;
  logic [15:0]            fetched_q;
  logic                   pend_q;
  logic                   skid_vld_q;
  logic [INSTR_WIDTH-1:0] skid_q;
  logic                   busy_q;
  logic                   done_q;

  logic                   active;
  logic                   wr_skid;
  logic                   wr_new;
  logic                   to_skid;
  logic                   eop_hit;
  logic                   rd_go;
  logic                   drain_empty;
  logic [ADDR_WIDTH-1:0]  addr_d;
  logic [15:0]            remain_d;
  logic [15:0]            fetched_d;

  assign active = (state_q == FETCH) || (state_q == DRAIN);

  // A read is only issued with the skid empty and the FIFO open, so a
  // returning word never meets an occupied skid register.
  assign wr_skid = active && skid_vld_q && !fifo_full;
  assign wr_new  = active && pend_q && !skid_vld_q && !fifo_full;
  assign to_skid = active && pend_q && !skid_vld_q && fifo_full;

  assign o_instr_wr_en = wr_skid || wr_new;
  assign o_instr       = wr_skid ? skid_q : (wr_new ? i_instr : '0);

`ifdef INSTR_PREFETCH_EOP_EN
  assign eop_hit = o_instr_wr_en && (o_instr[63:56] == 8'hFF);
`else
  assign eop_hit = 1'b0;
`endif

  assign rd_go = (state_q == FETCH) && (remain_q != 16'd0) && !fifo_full
                 && !skid_vld_q && !eop_hit;

  // True when whatever is outstanding leaves the block during this cycle.
  assign drain_empty = !(pend_q && !wr_new) && !(skid_vld_q && !wr_skid);

  assign addr_d    = addr_q + ADDR_ONE;
  assign remain_d  = remain_q - 16'd1;
  assign fetched_d = fetched_q + 16'd1;

  assign i_instr_addr  = addr_q;
  assign i_instr_rd_en = rd_go;
  assign busy          = busy_q;
  assign done          = done_q;
  assign fetched       = fetched_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      fetched_q  <= '0;
      pend_q     <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      pend_q <= rd_go;
      done_q <= 1'b0;

      if (to_skid) begin
        skid_vld_q <= 1'b1;
        skid_q     <= i_instr;
      end else if (wr_skid) begin
        skid_vld_q <= 1'b0;
      end

      if (o_instr_wr_en) begin
        fetched_q <= fetched_d;
      end

      if (rd_go) begin
        addr_q   <= addr_d;
        remain_q <= remain_d;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            fetched_q <= '0;
            addr_q    <= base_addr;
            remain_q  <= instr_count;
            busy_q    <= 1'b1;
            if (instr_count == 16'd0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= FETCH;
            end
          end
        end
        FETCH: begin
          if (eop_hit) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (rd_go && (remain_q == 16'd1)) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (eop_hit || drain_empty) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
